port_input_debounce: RTL and testbench

Input-conditioning stage upstream of the SoC's port 3 input pins. It takes asynchronous board-level inputs (buttons, jumpers, external strobes), synchronises them into the `clk` domain and debounces each bit independently. It then presents a stable port value plus one-cycle change and falling-edge strobes; the falling-edge strobes feed the CPU's P30–P33 edge-triggered IRQ inputs. It runs on the same divided PLL clock as the SoC.

---
 rtl/z8_io_pkg.sv | 27 ++
 rtl/debounce_bit.sv | 55 +++++
 rtl/port_input_debounce.sv | 53 +++++
 tb/tb_port_input_debounce.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/z8_io_pkg.sv
// Port-3 input constants shared across the SoC: default width/reset level and
// the mapping of debounced falling-edge strobes onto the CPU's P30-P33 IRQs.
package z8_io_pkg;

   localparam int unsigned P3_WIDTH = 4;
   localparam logic [P3_WIDTH-1:0] P3_RESET_VALUE = 4'hF;

   typedef enum logic [1:0] {
      IRQ0 = 2'd0,
      IRQ1 = 2'd1,
      IRQ2 = 2'd2,
      IRQ3 = 2'd3
   } p3_irq_e;

   // fall[n] drives IRQn; MSB-first field order keeps the cast bit-aligned
   typedef struct packed {
      logic irq3;
      logic irq2;
      logic irq1;
      logic irq0;
   } p3_irq_req_t;

   function automatic p3_irq_req_t fall_to_irq(input logic [P3_WIDTH-1:0] fall);
      return p3_irq_req_t'(fall);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser, tick-qualified stability counter and the
// registered level plus one-cycle change / falling-edge strobes.
module debounce_bit #(
   parameter int unsigned STABLE_TICKS = 4,
   parameter logic        RESET_BIT    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tick,
   input  logic i_pin,
   output logic o_level,
   output logic o_changed,
   output logic o_fall
);

   localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic          r_meta;
   logic          r_sync;
   logic [CW-1:0] r_cnt;
   logic          w_mismatch;

   assign w_mismatch = (r_sync != o_level);

   // Any matching sample clears the run, so only uninterrupted mismatches count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta    <= RESET_BIT;
         r_sync    <= RESET_BIT;
         o_level   <= RESET_BIT;
         r_cnt     <= '0;
         o_changed <= 1'b0;
         o_fall    <= 1'b0;
      end else begin
         r_meta    <= i_pin;
         r_sync    <= r_meta;
         o_changed <= 1'b0;
         o_fall    <= 1'b0;
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (i_tick) begin
            if (r_cnt == LAST) begin
               o_level   <= r_sync;
               r_cnt     <= '0;
               o_changed <= 1'b1;
               o_fall    <= ~r_sync;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/port_input_debounce.sv
// Port-3 input conditioning: shared debounce tick prescaler feeding one
// independent synchronise-and-debounce slice per pin.
module port_input_debounce
   import z8_io_pkg::*;
#(
   parameter int unsigned       WIDTH        = P3_WIDTH,
   parameter int unsigned       STABLE_TICKS = 4,
   parameter int unsigned       PRESCALE     = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE  = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] port_out,
   output logic [WIDTH-1:0] changed,
   output logic [WIDTH-1:0] fall
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pcnt;
   logic          w_tick;

   // With PRESCALE=1 the count is pinned at 0 and every cycle is a tick
   assign w_tick = (r_pcnt == P_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + PW'(1);
      end
   end

   for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
      debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_BIT    (RESET_VALUE[g])
      ) u_bit (
         .clk       (clk),
         .reset     (reset),
         .i_tick    (w_tick),
         .i_pin     (pins_in[g]),
         .o_level   (port_out[g]),
         .o_changed (changed[g]),
         .o_fall    (fall[g])
      );
   end

endmodule

// File: tb/tb_port_input_debounce.sv
// Bench for port_input_debounce: directed scenarios plus random pin traffic on
// two configurations, every cycle compared against a behavioural model.
module tb_port_input_debounce;

   localparam int A_PRE = 1;
   localparam int A_ST  = 4;
   localparam int B_PRE = 3;
   localparam int B_ST  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] pins;
   logic [3:0] port_a, chg_a, fall_a;
   logic [3:0] port_b, chg_b, fall_b;

   int checks   = 0;
   int failures = 0;

   logic [3:0] m_s1[2], m_s2[2], m_port[2], m_chg[2], m_fall[2];
   int         m_run[2][4];
   int         m_k[2];
   bit         m_tick[2];

   port_input_debounce #(.WIDTH(4), .STABLE_TICKS(A_ST), .PRESCALE(A_PRE), .RESET_VALUE(4'hF)) dut_a (
      .clk(clk), .reset(reset), .pins_in(pins), .port_out(port_a), .changed(chg_a), .fall(fall_a));

   port_input_debounce #(.WIDTH(4), .STABLE_TICKS(B_ST), .PRESCALE(B_PRE), .RESET_VALUE(4'hF)) dut_b (
      .clk(clk), .reset(reset), .pins_in(pins), .port_out(port_b), .changed(chg_b), .fall(fall_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: a bit flips once sync has disagreed with it across ST ticks in a row
   task automatic model_edge(input int i);
      int p;
      int st;
      p  = (i == 0) ? A_PRE : B_PRE;
      st = (i == 0) ? A_ST  : B_ST;
      if (reset) begin
         m_s1[i] = 4'hF; m_s2[i] = 4'hF; m_port[i] = 4'hF;
         m_chg[i] = 4'h0; m_fall[i] = 4'h0;
         for (int b = 0; b < 4; b++) m_run[i][b] = 0;
         m_k[i] = 0;
         m_tick[i] = 1'b0;
      end else begin
         m_tick[i] = ((m_k[i] % p) == p - 1);
         m_k[i]++;
         m_chg[i] = 4'h0;
         m_fall[i] = 4'h0;
         for (int b = 0; b < 4; b++) begin
            if (m_s2[i][b] == m_port[i][b]) begin
               m_run[i][b] = 0;
            end else if (m_tick[i]) begin
               m_run[i][b]++;
               if (m_run[i][b] == st) begin
                  m_port[i][b] = m_s2[i][b];
                  m_chg[i][b]  = 1'b1;
                  m_fall[i][b] = ~m_s2[i][b];
                  m_run[i][b]  = 0;
               end
            end
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = pins;
      end
   endtask

   task automatic check_all();
      chk("a_port", port_a, m_port[0]);
      chk("a_chg",  chg_a,  m_chg[0]);
      chk("a_fall", fall_a, m_fall[0]);
      chk("b_port", port_b, m_port[1]);
      chk("b_chg",  chg_b,  m_chg[1]);
      chk("b_fall", fall_b, m_fall[1]);
      chk("b_tick_align", {3'b000, (|chg_b) & ~m_tick[1]}, 4'h0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) cycle();
   endtask

   initial begin
      int  lat;
      bit  seen;
      logic [3:0] tgt;

      // Reset with pins held low, then the debounced fall to 0
      reset = 1'b1;
      pins  = 4'h0;
      run(3);
      chk("rst_port", port_a, 4'hF);
      chk("rst_chg",  chg_a,  4'h0);
      chk("rst_fall", fall_a, 4'h0);
      reset = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         cycle();
         chk("rel_a_port", port_a, (e >= 5) ? 4'h0 : 4'hF);
         chk("rel_a_chg",  chg_a,  (e == 5) ? 4'hF : 4'h0);
         chk("rel_a_fall", fall_a, (e == 5) ? 4'hF : 4'h0);
         chk("rel_b_port", port_b, (e >= 5) ? 4'h0 : 4'hF);
      end

      // Clean fall on bit 0
      pins = 4'hF;
      run(12);
      pins = 4'hE;
      for (int e = 0; e <= 6; e++) begin
         cycle();
         chk("fall0_port", port_a, (e >= 5) ? 4'hE : 4'hF);
         chk("fall0_chg",  chg_a,  (e == 5) ? 4'h1 : 4'h0);
         chk("fall0_fall", fall_a, (e == 5) ? 4'h1 : 4'h0);
      end

      // Glitch of 3 samples rejected, 4 samples accepted
      pins = 4'hF;
      run(12);
      pins = 4'hD;
      run(3);
      pins = 4'hF;
      for (int e = 0; e < 10; e++) begin
         cycle();
         chk("glitch_port", port_a, 4'hF);
         chk("glitch_chg",  chg_a,  4'h0);
      end
      pins = 4'hD;
      for (int e = 0; e <= 5; e++) begin
         cycle();
         if (e == 3) pins = 4'hF;
         chk("run4_port", port_a, (e >= 5) ? 4'hD : 4'hF);
         chk("run4_fall", fall_a, (e == 5) ? 4'h2 : 4'h0);
      end

      // Rise on bit 2 pulses changed but not fall
      pins = 4'hB;
      run(14);
      pins = 4'hF;
      for (int e = 0; e <= 6; e++) begin
         cycle();
         chk("rise2_port", port_a, (e >= 5) ? 4'hF : 4'hB);
         chk("rise2_chg",  chg_a,  (e == 5) ? 4'h4 : 4'h0);
         chk("rise2_fall", fall_a, 4'h0);
      end

      // Prescaled latency bound from every tick phase
      for (int ph = 0; ph < 3; ph++) begin
         run(12 + ph);
         pins[3] = ~pins[3];
         tgt  = pins;
         seen = 1'b0;
         lat  = 0;
         for (int c = 1; c <= 12 && !seen; c++) begin
            cycle();
            if (chg_b[3]) begin
               seen = 1'b1;
               lat  = c;
            end
         end
         chk("pre_seen", {3'b000, seen}, 4'h1);
         chk("pre_lat_le8", {3'b000, (lat <= 2 + B_ST * B_PRE)}, 4'h1);
         chk("pre_port", port_b, tgt);
      end

      // Reset at count 3 of 4: no pulse, full run needed afterwards
      pins = 4'hF;
      run(14);
      pins = 4'hE;
      run(5);
      reset = 1'b1;
      cycle();
      chk("midrst_port", port_a, 4'hF);
      chk("midrst_chg",  chg_a,  4'h0);
      chk("midrst_fall", fall_a, 4'h0);
      reset = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         cycle();
         chk("post_rst_port", port_a, (e >= 5) ? 4'hE : 4'hF);
         chk("post_rst_chg",  chg_a,  (e == 5) ? 4'h1 : 4'h0);
      end

      // Random pin traffic with occasional resets
      for (int s = 0; s < 80; s++) begin
         pins = 4'($urandom);
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b1;
            cycle();
            reset = 1'b0;
         end
         run($urandom_range(1, 10));
      end
      run(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
